// File: rtl/ddr_cmd_responder.sv
// ddr_cmd_responder
//
// Behavioural responder for a DDR command bus. It tracks the state of each
// bank (IDLE / ACTIVATING / ACTIVE / PRECHARGING) and enforces tRCD, tRAS and
// tRP. It returns read data strobes CL cycles after each legal RD. Illegal
// commands are dropped without touching any bank state.
//
// Optional feature macro: DDR_RESP_ERR_EN
//   defined   -> err_valid / err_code report the cause of each dropped command
//   undefined -> err_valid / err_code are tied to 0 (commands are still dropped)
//
// Ports
//   clock_t    in   sole clock, rising edge
//   reset      in   synchronous, active-high; wins over cmd_valid
//   cmd_valid  in   command present this cycle
//   cmd_op     in   00 ACT, 01 PRE, 10 RD, 11 WR
//   cmd_bg     in   bank group  (bank index = {cmd_bg, cmd_ba})
//   cmd_ba     in   bank address
//   cmd_row    in   row address (ignored by PRE)
//   bank_open  out  per bank, 1 while ACTIVATING or ACTIVE
//   rd_valid   out  one-cycle read-return strobe
//   rd_bank    out  bank index of the returned read
//   err_valid  out  one-cycle illegal-command strobe, one cycle after the command
//   err_code   out  1 ACT not idle, 2 RD/WR not active, 3 PRE before tRAS, 4 row miss
module ddr_cmd_responder #(
    parameter int NUM_BANKS = 16,
    parameter int ROW_W     = 15,
    parameter int T_RCD     = 4,
    parameter int T_RAS     = 12,
    parameter int T_RP      = 10,
    parameter int CL        = 5
) (
    input  logic                 clock_t,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_op,
    input  logic [1:0]           cmd_bg,
    input  logic [1:0]           cmd_ba,
    input  logic [ROW_W-1:0]     cmd_row,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 rd_valid,
    output logic [3:0]           rd_bank,
    output logic                 err_valid,
    output logic [2:0]           err_code
);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_ACTIVATING  = 2'd1;
    localparam logic [1:0] ST_ACTIVE      = 2'd2;
    localparam logic [1:0] ST_PRECHARGING = 2'd3;

    localparam logic [1:0] OP_ACT = 2'b00;
    localparam logic [1:0] OP_PRE = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_WR  = 2'b11;

    // The timer saturates at the largest timing parameter (T_RAS in any
    // sensible configuration) so every threshold stays reachable and the
    // counter never wraps.
    localparam int T_SAT = (T_RAS > T_RP) ? ((T_RAS > T_RCD) ? T_RAS : T_RCD)
                                          : ((T_RP  > T_RCD) ? T_RP  : T_RCD);
    localparam int TIMER_W = $clog2(T_SAT + 1);

    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(T_SAT);
    localparam logic [TIMER_W-1:0] RCD_LAST  = TIMER_W'(T_RCD - 1);
    localparam logic [TIMER_W-1:0] RAS_LAST  = TIMER_W'(T_RAS - 1);
    localparam logic [TIMER_W-1:0] RP_LAST   = TIMER_W'(T_RP - 1);

    // With a threshold of 1 the bank must be usable on the very next cycle,
    // so the intermediate state is skipped altogether.
    localparam logic [1:0] ACT_NEXT = (T_RCD > 1) ? ST_ACTIVATING  : ST_ACTIVE;
    localparam logic [1:0] PRE_NEXT = (T_RP  > 1) ? ST_PRECHARGING : ST_IDLE;

    logic [1:0]         bank_state [NUM_BANKS];
    logic [TIMER_W-1:0] bank_timer [NUM_BANKS];
    logic [ROW_W-1:0]   bank_row   [NUM_BANKS];

    logic [3:0]         cmd_idx;
    logic               bank_in_range;
    logic [1:0]         sel_state;
    logic [TIMER_W-1:0] sel_timer;
    logic [ROW_W-1:0]   sel_row;
    logic [2:0]         cmd_err;
    logic               cmd_legal;
    logic               rd_accept;

    logic [CL-1:0]      pipe_v;
    logic [3:0]         pipe_bank [CL];

    function automatic logic [TIMER_W-1:0] timer_step(input logic [TIMER_W-1:0] t);
        return (t >= TIMER_MAX) ? TIMER_MAX : t + TIMER_W'(1);
    endfunction

    assign cmd_idx       = {cmd_bg, cmd_ba};
    assign bank_in_range = (32'(cmd_idx) < NUM_BANKS);

    // Look up the addressed bank and classify the command. A non-zero cmd_err
    // means the command is dropped. A PRE to an IDLE or PRECHARGING bank is
    // legal but changes nothing, because that bank is already closed.
    always_comb begin
        sel_state = ST_IDLE;
        sel_timer = '0;
        sel_row   = '0;
        cmd_err   = 3'd0;
        if (bank_in_range) begin
            sel_state = bank_state[cmd_idx];
            sel_timer = bank_timer[cmd_idx];
            sel_row   = bank_row[cmd_idx];
        end
        if (cmd_valid && bank_in_range) begin
            case (cmd_op)
                OP_ACT: begin
                    if (sel_state != ST_IDLE) begin
                        cmd_err = 3'd1;
                    end
                end
                OP_PRE: begin
                    if ((sel_state == ST_ACTIVATING) ||
                        ((sel_state == ST_ACTIVE) && (sel_timer < RAS_LAST))) begin
                        cmd_err = 3'd3;
                    end
                end
                OP_RD, OP_WR: begin
                    if (sel_state != ST_ACTIVE) begin
                        cmd_err = 3'd2;
                    end else if (sel_row != cmd_row) begin
                        cmd_err = 3'd4;
                    end
                end
                default: cmd_err = 3'd0;
            endcase
        end
    end

    assign cmd_legal = cmd_valid && bank_in_range && (cmd_err == 3'd0);
    assign rd_accept = cmd_legal && (cmd_op == OP_RD);

    // Per-bank FSM. The timer is cleared by ACT and by an effective PRE, and
    // it runs otherwise. The transition fires on the edge where the timer
    // steps to the threshold. The new state is therefore visible in the same
    // cycle in which the timer reads T_xx-1. This makes a follow-up command
    // exactly T_xx cycles after the opening command legal.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state[b] <= ST_IDLE;
                bank_timer[b] <= '0;
                bank_row[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (cmd_legal && (cmd_idx == 4'(b)) && (cmd_op == OP_ACT)) begin
                    bank_state[b] <= ACT_NEXT;
                    bank_timer[b] <= '0;
                    bank_row[b]   <= cmd_row;
                end else if (cmd_legal && (cmd_idx == 4'(b)) && (cmd_op == OP_PRE) &&
                             (bank_state[b] == ST_ACTIVE)) begin
                    bank_state[b] <= PRE_NEXT;
                    bank_timer[b] <= '0;
                end else begin
                    bank_timer[b] <= timer_step(bank_timer[b]);
                    if ((bank_state[b] == ST_ACTIVATING) &&
                        (timer_step(bank_timer[b]) >= RCD_LAST)) begin
                        bank_state[b] <= ST_ACTIVE;
                    end else if ((bank_state[b] == ST_PRECHARGING) &&
                                 (timer_step(bank_timer[b]) >= RP_LAST)) begin
                        bank_state[b] <= ST_IDLE;
                    end
                end
            end
        end
    end

    always_comb begin
        bank_open = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_open[b] = (bank_state[b] == ST_ACTIVATING) || (bank_state[b] == ST_ACTIVE);
        end
    end

    // Read-return shift pipeline. Stage CL-1 drives the outputs, so a RD that
    // is accepted on cycle N appears on cycle N+CL. The bank field is loaded
    // only for real returns, so rd_bank reads 0 whenever rd_valid is low.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            pipe_v <= '0;
            for (int i = 0; i < CL; i++) begin
                pipe_bank[i] <= '0;
            end
        end else begin
            pipe_v[0]    <= rd_accept;
            pipe_bank[0] <= rd_accept ? cmd_idx : 4'd0;
            for (int i = 1; i < CL; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_bank[i] <= pipe_bank[i-1];
            end
        end
    end

    assign rd_valid = pipe_v[CL-1];
    assign rd_bank  = pipe_bank[CL-1];

`ifdef DDR_RESP_ERR_EN
    // Error strobe is registered, one cycle after the offending command.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            err_valid <= cmd_valid && bank_in_range && (cmd_err != 3'd0);
            err_code  <= cmd_err;
        end
    end
`else
    assign err_valid = 1'b0;
    assign err_code  = 3'd0;
`endif

endmodule

// File: tb/tb_ddr_cmd_responder.sv
// tb_ddr_cmd_responder
//
// Self-checking bench for ddr_cmd_responder. A reference model follows each
// bank through the cycle numbers of its last ACT and PRE, and predicts
// legality, error causes, bank_open and read returns from those cycle
// distances. Directed sequences come first, followed by random traffic that
// includes occasional resets.
module tb_ddr_cmd_responder;

    localparam int NUM_BANKS = 16;
    localparam int ROW_W     = 15;
    localparam int T_RCD     = 4;
    localparam int T_RAS     = 12;
    localparam int T_RP      = 10;
    localparam int CL        = 5;

    localparam logic [1:0] OP_ACT = 2'b00;
    localparam logic [1:0] OP_PRE = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_WR  = 2'b11;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmd_valid;
    logic [1:0]           cmd_op;
    logic [1:0]           cmd_bg;
    logic [1:0]           cmd_ba;
    logic [ROW_W-1:0]     cmd_row;
    logic [NUM_BANKS-1:0] bank_open;
    logic                 rd_valid;
    logic [3:0]           rd_bank;
    logic                 err_valid;
    logic [2:0]           err_code;

    ddr_cmd_responder #(
        .NUM_BANKS(NUM_BANKS),
        .ROW_W    (ROW_W),
        .T_RCD    (T_RCD),
        .T_RAS    (T_RAS),
        .T_RP     (T_RP),
        .CL       (CL)
    ) dut (
        .clock_t  (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_bg   (cmd_bg),
        .cmd_ba   (cmd_ba),
        .cmd_row  (cmd_row),
        .bank_open(bank_open),
        .rd_valid (rd_valid),
        .rd_bank  (rd_bank),
        .err_valid(err_valid),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit checking    = 1'b0;
    bit post_reset  = 1'b0;

    bit m_open [NUM_BANKS];
    int m_act  [NUM_BANKS];
    int m_pre  [NUM_BANKS];
    int m_row  [NUM_BANKS];

    bit exp_rd_v  [64];
    int exp_rd_b  [64];
    bit exp_err_v [64];
    int exp_err_c [64];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     tag, cyc, observed, expected);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < NUM_BANKS; b++) begin
            m_open[b] = 1'b0;
            m_act[b]  = -1000;
            m_pre[b]  = -1000;
            m_row[b]  = 0;
        end
        for (int s = 0; s < 64; s++) begin
            exp_rd_v[s]  = 1'b0;
            exp_rd_b[s]  = 0;
            exp_err_v[s] = 1'b0;
            exp_err_c[s] = 0;
        end
    endfunction

    // Returns the error cause (0 = legal) and applies the effect of a legal
    // command. The decision uses only the distance in cycles since the last
    // ACT or PRE on the bank.
    function automatic int model_cmd(input logic [1:0] op, input int idx,
                                     input int row, input int now);
        int code;
        code = 0;
        case (op)
            OP_ACT: begin
                if (m_open[idx] || (now - m_pre[idx] < T_RP)) begin
                    code = 1;
                end else begin
                    m_open[idx] = 1'b1;
                    m_act[idx]  = now;
                    m_row[idx]  = row;
                end
            end
            OP_PRE: begin
                if (m_open[idx]) begin
                    if (now - m_act[idx] < T_RAS) begin
                        code = 3;
                    end else begin
                        m_open[idx] = 1'b0;
                        m_pre[idx]  = now;
                    end
                end
            end
            default: begin
                if (!m_open[idx] || (now - m_act[idx] < T_RCD)) begin
                    code = 2;
                end else if (row != m_row[idx]) begin
                    code = 4;
                end else if (op == OP_RD) begin
                    exp_rd_v[(now + CL) % 64] = 1'b1;
                    exp_rd_b[(now + CL) % 64] = idx;
                end
            end
        endcase
        return code;
    endfunction

    // One cycle: check the outputs of the current cycle at the negedge, then
    // drive this cycle's inputs and advance the model.
    task automatic applyStimulus(input bit rst, input bit v, input logic [1:0] op,
                                 input int idx, input int row);
        int slot;
        int code;
        logic [NUM_BANKS-1:0] exp_open;
        @(negedge clk);
        cyc++;
        slot = cyc % 64;
        if (checking) begin
            exp_open = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                exp_open[b] = m_open[b];
            end
            checkOutput("bank_open", 32'(bank_open), 32'(exp_open));
            checkOutput("rd_valid", 32'(rd_valid), 32'(exp_rd_v[slot]));
            if (exp_rd_v[slot] || post_reset) begin
                checkOutput("rd_bank", 32'(rd_bank), 32'(exp_rd_b[slot]));
            end
`ifdef DDR_RESP_ERR_EN
            checkOutput("err_valid", 32'(err_valid), 32'(exp_err_v[slot]));
            if (exp_err_v[slot] || post_reset) begin
                checkOutput("err_code", 32'(err_code), 32'(exp_err_c[slot]));
            end
`else
            checkOutput("err_valid", 32'(err_valid), 32'd0);
            checkOutput("err_code", 32'(err_code), 32'd0);
`endif
        end
        exp_rd_v[slot]  = 1'b0;
        exp_rd_b[slot]  = 0;
        exp_err_v[slot] = 1'b0;
        exp_err_c[slot] = 0;
        post_reset = rst;

        reset     = rst;
        cmd_valid = v;
        cmd_op    = op;
        cmd_bg    = 2'(idx >> 2);
        cmd_ba    = 2'(idx);
        cmd_row   = ROW_W'(row);

        if (rst) begin
            model_reset();
        end else if (v) begin
            code = model_cmd(op, idx, row, cyc);
            exp_err_v[(cyc + 1) % 64] = (code != 0);
            exp_err_c[(cyc + 1) % 64] = code;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, OP_ACT, 0, 0);
    endtask

    task automatic issue(input logic [1:0] op, input int idx, input int row);
        applyStimulus(1'b0, 1'b1, op, idx, row);
    endtask

    initial begin
        int r;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_ACT;
        cmd_bg    = 2'd0;
        cmd_ba    = 2'd0;
        cmd_row   = '0;
        model_reset();

        applyStimulus(1'b1, 1'b0, OP_ACT, 0, 0);
        applyStimulus(1'b1, 1'b0, OP_ACT, 0, 0);
        checking = 1'b1;
        $display("[TB] directed sequences");

        // ACT then RD exactly tRCD later; return CL later.
        issue(OP_ACT, 5, 'h12);
        idle(3);
        issue(OP_RD, 5, 'h12);
        idle(6);

        // RD one cycle too early.
        issue(OP_ACT, 3, 1);
        idle(2);
        issue(OP_RD, 3, 1);
        idle(8);

        // Row miss, PRE one cycle early, then PRE on the boundary.
        issue(OP_ACT, 0, 7);
        idle(4);
        issue(OP_RD, 0, 9);
        idle(5);
        issue(OP_PRE, 0, 0);
        issue(OP_PRE, 0, 0);
        idle(2);

        // ACT one cycle before tRP expires, then on the boundary.
        issue(OP_ACT, 2, 3);
        idle(11);
        issue(OP_PRE, 2, 0);
        idle(8);
        issue(OP_ACT, 2, 3);
        issue(OP_ACT, 2, 3);
        idle(2);

        // Back-to-back reads, a write, PRE to an idle bank.
        issue(OP_ACT, 6, 5);
        idle(3);
        issue(OP_RD, 6, 5);
        issue(OP_RD, 6, 5);
        issue(OP_WR, 6, 5);
        issue(OP_RD, 6, 5);
        issue(OP_PRE, 9, 0);
        idle(6);

        // Reads in flight are killed by reset, which also beats cmd_valid.
        issue(OP_ACT, 4, 2);
        idle(3);
        issue(OP_RD, 4, 2);
        issue(OP_RD, 4, 2);
        applyStimulus(1'b1, 1'b1, OP_ACT, 7, 0);
        idle(8);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 4) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), OP_ACT, 1, 0);
            end else if (r < 300) begin
                idle(1);
            end else begin
                issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 2)));
            end
        end
        idle(CL + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
